// File: rtl/gcn_pkg.sv
// Shared types and helpers for the GCN sparse-times-dense engine:
// FSM encoding, Q8.8 scaling, sparse header layout and signed saturation.
package gcn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LD_W  = 2'd1,
        ST_LD_IN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int FRAC_BITS   = 8;
    localparam int HDR_ROW_MSB = 15;
    localparam int HDR_ROW_LSB = 8;
    localparam int HDR_COL_MSB = 7;
    localparam int HDR_COL_LSB = 0;

    // Clamp v to the signed range of a w-bit word (16 bits unless told otherwise).
    function automatic logic signed [63:0] sat16(input logic signed [63:0] v, input int w = 16);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gcn_mac_lane.sv
// One weight-column lane: Q8.8 multiply, arithmetic rescale, saturate the
// product term, then saturating add onto the current accumulator value.
module gcn_mac_lane
    import gcn_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] d_i,
    input  logic [DATA_W-1:0] w_i,
    input  logic [DATA_W-1:0] acc_i,
    output logic [DATA_W-1:0] acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] scaled;
    logic signed [DATA_W-1:0]   term;
    logic signed [DATA_W:0]     sum;

    always_comb begin
        prod   = $signed({{DATA_W{d_i[DATA_W-1]}}, d_i}) * $signed({{DATA_W{w_i[DATA_W-1]}}, w_i});
        scaled = prod >>> FRAC_BITS;
        term   = DATA_W'(sat16(64'(scaled), DATA_W));
        sum    = $signed({acc_i[DATA_W-1], acc_i}) + $signed({term[DATA_W-1], term});
        acc_o  = DATA_W'(sat16(64'(sum), DATA_W));
    end

endmodule

// File: rtl/gcn_spmm_engine.sv
// Sparse adjacency x dense weight engine: loads weights, accumulates sparse
// {header,data} entries into per-row lane accumulators, then streams results.
// Define GCN_RELU_EN to clamp negative results to zero on output.
module gcn_spmm_engine
    import gcn_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int N_CH     = 2,
    parameter int W_ROWS   = 32,
    parameter int OUT_ROWS = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_cmd,
    input  logic [DATA_W-1:0] i_p,
    output logic              o_result,
    output logic              o_rdy,
    output logic [DATA_W-1:0] o_p,
    output logic              o_err
);

    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int CW = $clog2(W_ROWS);
    localparam int LW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [8:0] W_LAST = 9'(W_ROWS - 1);
    localparam logic [8:0] O_LAST = 9'(OUT_ROWS - 1);
    localparam logic [3:0] L_LAST = 4'(N_CH - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wts_q [N_CH][W_ROWS];
    logic [DATA_W-1:0] acc_q [OUT_ROWS][N_CH];
    logic [DATA_W-1:0] lane_acc [N_CH];
    logic [8:0]        row_q;
    logic [3:0]        lane_q;
    logic              hdr_phase_q;
    logic [7:0]        hdr_row_q, hdr_col_q;
    logic              err_q;
    logic              in_range, last_w, last_out;
    logic              start_job, load_w, take_word, shift_out;
    logic [RW-1:0]     acc_row;
    logic [CW-1:0]     w_col;
    logic [DATA_W-1:0] sel;

    assign in_range = ({1'b0, hdr_row_q} < 9'(OUT_ROWS)) && ({1'b0, hdr_col_q} < 9'(W_ROWS));
    assign acc_row  = in_range ? RW'(hdr_row_q) : '0;
    assign w_col    = in_range ? CW'(hdr_col_q) : '0;
    assign last_w   = (lane_q == L_LAST) && (row_q == W_LAST);
    assign last_out = (lane_q == L_LAST) && (row_q == O_LAST);
    assign o_err    = err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        gcn_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .d_i   (i_p),
            .w_i   (wts_q[g][w_col]),
            .acc_i (acc_q[acc_row][g]),
            .acc_o (lane_acc[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_req) state_d = ST_LD_W;
            ST_LD_W:  if (last_w) state_d = ST_LD_IN;
            ST_LD_IN: if (hdr_phase_q && i_cmd) state_d = ST_OUT;
            ST_OUT:   if (last_out) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_result  = 1'b0;
        o_rdy     = 1'b0;
        start_job = 1'b0;
        load_w    = 1'b0;
        take_word = 1'b0;
        shift_out = 1'b0;
        case (state_q)
            ST_IDLE:  begin o_result = 1'b1; start_job = i_req; end
            ST_LD_W:  load_w = 1'b1;
            ST_LD_IN: take_word = 1'b1;
            ST_OUT:   begin o_rdy = 1'b1; shift_out = 1'b1; end
            default:  o_result = 1'b0;
        endcase
        sel = acc_q[RW'(row_q)][LW'(lane_q)];
`ifdef GCN_RELU_EN
        o_p = (o_rdy && !sel[DATA_W-1]) ? sel : '0;
`else
        o_p = o_rdy ? sel : '0;
`endif
    end

    // row_q/lane_q serve both the column-major weight load and the row-major readout.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            lane_q      <= '0;
            hdr_phase_q <= 1'b0;
            hdr_row_q   <= '0;
            hdr_col_q   <= '0;
            err_q       <= 1'b0;
            for (int r = 0; r < OUT_ROWS; r++)
                for (int c = 0; c < N_CH; c++) acc_q[r[RW-1:0]][c[LW-1:0]] <= '0;
            for (int c = 0; c < N_CH; c++)
                for (int r = 0; r < W_ROWS; r++) wts_q[c[LW-1:0]][r[CW-1:0]] <= '0;
        end else begin
            if (start_job) begin
                row_q       <= '0;
                lane_q      <= '0;
                hdr_phase_q <= 1'b0;
                err_q       <= 1'b0;
                for (int r = 0; r < OUT_ROWS; r++)
                    for (int c = 0; c < N_CH; c++) acc_q[r[RW-1:0]][c[LW-1:0]] <= '0;
            end
            if (load_w) begin
                wts_q[LW'(lane_q)][CW'(row_q)] <= i_p;
                if (row_q == W_LAST) begin
                    row_q  <= '0;
                    lane_q <= last_w ? 4'd0 : lane_q + 4'd1;
                end else begin
                    row_q <= row_q + 9'd1;
                end
            end
            if (take_word) begin
                if (!hdr_phase_q) begin
                    hdr_row_q   <= i_p[HDR_ROW_MSB:HDR_ROW_LSB];
                    hdr_col_q   <= i_p[HDR_COL_MSB:HDR_COL_LSB];
                    hdr_phase_q <= 1'b1;
                end else begin
                    hdr_phase_q <= 1'b0;
                    if (in_range) begin
                        for (int c = 0; c < N_CH; c++) acc_q[acc_row][c[LW-1:0]] <= lane_acc[c];
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
            if (shift_out) begin
                if (lane_q == L_LAST) begin
                    lane_q <= '0;
                    row_q  <= last_out ? 9'd0 : row_q + 9'd1;
                end else begin
                    lane_q <= lane_q + 4'd1;
                end
            end
        end
    end

endmodule
